// File: rtl/dpram_write_packer.sv
// Write-side packer for the feature-map dual-port RAM.
// Collects a byte stream into 16-byte words and writes them row by row,
// with a partial write at each row end. Rows start at base_addr and are
// spaced row_pitch bytes apart.

// One accumulator lane: holds a single byte of the word being packed and
// produces that lane's contribution to the outgoing write word.
module dpram_pack_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  accept,   // byte taken from the stream this cycle
  input  logic                  close,    // accepted byte closes the current chunk
  input  logic                  sel,      // this lane is the current write position
  input  logic                  keep,     // lane index <= current position
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] wbyte
);
  logic [DATA_WIDTH-1:0] acc_q, acc_d;

  // Capture the byte on its lane; clear every lane when a chunk closes.
  always_comb begin
    acc_d = acc_q;
    if (accept) begin
      if (close)    acc_d = '0;
      else if (sel) acc_d = in_data;
    end
  end

  // Lane storage; a reset discards any partly filled word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  // Lanes above the closing position are forced to zero.
  assign wbyte = !keep ? '0 : (sel ? in_data : acc_q);
endmodule

module dpram_write_packer #(
  parameter int ADDR_WIDTH  = 19,
  parameter int DATA_WIDTH  = 8,
  parameter int INOUT_WIDTH = 128,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [LEN_WIDTH-1:0]   row_len,
  input  logic [LEN_WIDTH-1:0]   num_rows,
  input  logic [ADDR_WIDTH-1:0]  row_pitch,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   in_ready,
  output logic                   we_b,
  output logic [ADDR_WIDTH-1:0]  addr_b,
  output logic [INOUT_WIDTH-1:0] din_b,
  output logic [4:0]             size,
  output logic                   busy,
  output logic                   done
);
  localparam int NUM_LANES = INOUT_WIDTH / DATA_WIDTH;
  localparam int BW        = $clog2(NUM_LANES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   row_len_q, row_len_d;
  logic [LEN_WIDTH-1:0]   num_rows_q, num_rows_d;
  logic [ADDR_WIDTH-1:0]  row_pitch_q, row_pitch_d;
  logic [ADDR_WIDTH-1:0]  row_base_q, row_base_d;
  logic [ADDR_WIDTH-1:0]  chunk_off_q, chunk_off_d;
  logic [BW-1:0]          byte_cnt_q, byte_cnt_d;
  logic [LEN_WIDTH-1:0]   row_cnt_q, row_cnt_d;
  logic [LEN_WIDTH-1:0]   row_rem_q, row_rem_d;   // bytes still expected in this row
  logic                   we_b_q, we_b_d;
  logic [ADDR_WIDTH-1:0]  addr_b_q, addr_b_d;
  logic [INOUT_WIDTH-1:0] din_b_q, din_b_d;
  logic [4:0]             size_q, size_d;

  logic accept, last_in_row, last_row, close;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] wdata;

  assign accept      = in_valid && (state_q == S_RUN);
  assign last_in_row = (row_rem_q == LEN_WIDTH'(1));
  assign last_row    = (row_cnt_q == num_rows_q - LEN_WIDTH'(1));
  assign close       = (byte_cnt_q == BW'(NUM_LANES - 1)) || last_in_row;

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      dpram_pack_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .clk     (clk),
        .rst     (rst),
        .accept  (accept),
        .close   (close),
        .sel     (byte_cnt_q == BW'(i)),
        .keep    (BW'(i) <= byte_cnt_q),
        .in_data (in_data),
        .wbyte   (wdata[i])
      );
    end
  endgenerate

  // Next-state logic: configuration capture, chunk/row bookkeeping, write issue.
  always_comb begin
    state_d     = state_q;
    row_len_d   = row_len_q;
    num_rows_d  = num_rows_q;
    row_pitch_d = row_pitch_q;
    row_base_d  = row_base_q;
    chunk_off_d = chunk_off_q;
    byte_cnt_d  = byte_cnt_q;
    row_cnt_d   = row_cnt_q;
    row_rem_d   = row_rem_q;
    we_b_d      = 1'b0;
    addr_b_d    = addr_b_q;
    din_b_d     = din_b_q;
    size_d      = size_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          row_len_d   = row_len;
          num_rows_d  = num_rows;
          row_pitch_d = row_pitch;
          row_base_d  = base_addr;
          chunk_off_d = '0;
          byte_cnt_d  = '0;
          row_cnt_d   = '0;
          row_rem_d   = row_len;
          state_d     = (row_len == '0 || num_rows == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + BW'(1);
          row_rem_d  = row_rem_q - LEN_WIDTH'(1);
          if (close) begin
            we_b_d      = 1'b1;
            addr_b_d    = row_base_q + chunk_off_q;
            size_d      = 5'(byte_cnt_q) + 5'd1;
            din_b_d     = wdata;
            byte_cnt_d  = '0;
            chunk_off_d = chunk_off_q + ADDR_WIDTH'(NUM_LANES);
          end
          if (last_in_row) begin
            chunk_off_d = '0;
            row_base_d  = row_base_q + row_pitch_q;
            row_cnt_d   = row_cnt_q + LEN_WIDTH'(1);
            row_rem_d   = row_len_q;
            if (last_row) state_d = S_FIN;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_len_q   <= '0;
      num_rows_q  <= '0;
      row_pitch_q <= '0;
      row_base_q  <= '0;
      chunk_off_q <= '0;
      byte_cnt_q  <= '0;
      row_cnt_q   <= '0;
      row_rem_q   <= '0;
      we_b_q      <= 1'b0;
      addr_b_q    <= '0;
      din_b_q     <= '0;
      size_q      <= '0;
    end else begin
      state_q     <= state_d;
      row_len_q   <= row_len_d;
      num_rows_q  <= num_rows_d;
      row_pitch_q <= row_pitch_d;
      row_base_q  <= row_base_d;
      chunk_off_q <= chunk_off_d;
      byte_cnt_q  <= byte_cnt_d;
      row_cnt_q   <= row_cnt_d;
      row_rem_q   <= row_rem_d;
      we_b_q      <= we_b_d;
      addr_b_q    <= addr_b_d;
      din_b_q     <= din_b_d;
      size_q      <= size_d;
    end
  end

  assign in_ready = (state_q == S_RUN);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FIN);
  assign we_b     = we_b_q;
  assign addr_b   = addr_b_q;
  assign din_b    = din_b_q;
  assign size     = size_q;
endmodule

// File: tb/tb_dpram_write_packer.sv
// Randomized bench for dpram_write_packer against a row/chunk reference model.
module tb_dpram_write_packer;
  localparam int AW = 19, DW = 8, IW = 128, LW = 16;

  logic          clk = 1'b0;
  logic          rst, start, in_valid;
  logic [AW-1:0] base_addr, row_pitch;
  logic [LW-1:0] row_len, num_rows;
  logic [DW-1:0] in_data;
  logic          in_ready, we_b, busy, done;
  logic [AW-1:0] addr_b;
  logic [IW-1:0] din_b;
  logic [4:0]    size;

  dpram_write_packer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .row_len(row_len),
    .num_rows(num_rows), .row_pitch(row_pitch), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .size(size),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [4:0]    s;
    logic [IW-1:0] d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] sdat[$];
  int         n_cmp = 0, n_bad = 0;
  logic       e_we, e_done, e_ready, e_busy;
  int         m_pos, m_row, m_idx, m_len, m_rows;
  bit         xfer_done;

  task automatic chk(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: expected writes straight from the row/chunk layout rules.
  task automatic build(input longint base, input int len, input int rows, input longint pitch, input int mode);
    int idx;
    sdat.delete();
    exp_q.delete();
    for (int k = 0; k < len * rows; k++)
      case (mode)
        0:       sdat.push_back(8'(k));
        1:       sdat.push_back(8'($urandom));
        default: sdat.push_back(8'(8'hAA + 8'h11 * k));
      endcase
    idx = 0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c * 16 < len; c++) begin
        wr_t w;
        int  sz;
        sz  = (len - 16 * c) < 16 ? (len - 16 * c) : 16;
        w.a = AW'(base + longint'(r) * pitch + 16 * c);
        w.s = 5'(sz);
        w.d = '0;
        for (int k = 0; k < sz; k++) w.d[8*k +: 8] = sdat[idx + k];
        idx += sz;
        exp_q.push_back(w);
      end
  endtask

  // Advance to the next negedge and compare every output against the model.
  task automatic clk_chk();
    wr_t w;
    @(negedge clk);
    chk("we_b", IW'(we_b), IW'(e_we));
    chk("done", IW'(done), IW'(e_done));
    chk("in_ready", IW'(in_ready), IW'(e_ready));
    chk("busy", IW'(busy), IW'(e_busy));
    if (we_b && e_we) begin
      if (exp_q.size() == 0) chk("extra_write", IW'(1), IW'(0));
      else begin
        w = exp_q.pop_front();
        chk("addr_b", IW'(addr_b), IW'(w.a));
        chk("size", IW'(size), IW'(w.s));
        chk("din_b", din_b, w.d);
      end
    end
  endtask

  task automatic do_start(input longint base, input int len, input int rows, input longint pitch, input int mode);
    build(base, len, rows, pitch, mode);
    base_addr = AW'(base); row_len = LW'(len); num_rows = LW'(rows); row_pitch = AW'(pitch);
    start = 1'b1; in_valid = 1'b0;
    m_pos = 0; m_row = 0; m_idx = 0; m_len = len; m_rows = rows;
    e_we = 1'b0; e_busy = 1'b1;
    if (len == 0 || rows == 0) begin e_done = 1'b1; e_ready = 1'b0; xfer_done = 1'b1; end
    else                       begin e_done = 1'b0; e_ready = 1'b1; xfer_done = 1'b0; end
    clk_chk();
    start = 1'b0;
  endtask

  // One cycle of stimulus; st pulses start with scrambled config (must be ignored).
  task automatic step(input bit v, input bit st);
    bit n_we, n_done, n_ready;
    in_valid = v;
    in_data  = (m_idx < sdat.size()) ? sdat[m_idx] : 8'($urandom);
    start    = st;
    if (st) begin
      base_addr = AW'($urandom); row_len = LW'($urandom_range(40, 1));
      num_rows = LW'($urandom_range(4, 1)); row_pitch = AW'($urandom);
    end
    n_we = 1'b0; n_done = 1'b0; n_ready = e_ready;
    if (v && e_ready) begin
      n_we = (m_pos % 16 == 15) || (m_pos == m_len - 1);
      m_idx++;
      if (m_pos == m_len - 1) begin
        m_pos = 0;
        m_row++;
        if (m_row == m_rows) begin n_ready = 1'b0; n_done = 1'b1; xfer_done = 1'b1; end
      end else m_pos++;
    end
    e_we = n_we; e_done = n_done; e_ready = n_ready; e_busy = n_ready || n_done;
    clk_chk();
    start = 1'b0;
  endtask

  task automatic run(input int duty, input int poke);
    int cyc = 0;
    while (!xfer_done && cyc < 3000) begin
      step(duty >= 100 ? 1'b1 : ($urandom_range(99, 0) < duty), cyc == poke);
      cyc++;
    end
    chk("xfer_complete", IW'(xfer_done), IW'(1));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("writes_drained", IW'(exp_q.size()), IW'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    base_addr = '0; row_len = '0; num_rows = '0; row_pitch = '0;
    e_we = 1'b0; e_done = 1'b0; e_ready = 1'b0; e_busy = 1'b0;
    m_pos = 0; m_row = 0; m_idx = 0; m_len = 0; m_rows = 0; xfer_done = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_we_b", IW'(we_b), IW'(0));
    chk("rst_busy", IW'(busy), IW'(0));
    chk("rst_done", IW'(done), IW'(0));
    chk("rst_in_ready", IW'(in_ready), IW'(0));
    chk("rst_addr_b", IW'(addr_b), IW'(0));
    chk("rst_size", IW'(size), IW'(0));
    chk("rst_din_b", din_b, IW'(0));
    rst = 1'b0;
    step(1'b0, 1'b0);

    // Single full word
    do_start(64'h100, 16, 1, 0, 0);  run(100, -1);
    // Two rows of 20 with a start pulse mid-transfer
    do_start(0, 20, 2, 32, 0);       run(100, 5);
    // One-byte rows
    do_start(0, 1, 3, 416, 2);       run(100, -1);
    // Same as two rows of 20 but with ~50% valid gaps
    do_start(0, 20, 2, 32, 0);       run(50, 7);

    // Empty transfers, second start while in FIN
    do_start(64'h40, 0, 3, 16, 1);   step(1'b0, 1'b1); step(1'b0, 1'b0);
    do_start(64'h40, 5, 0, 16, 1);   run(100, -1);

    // Reset after 7 accepted bytes drops the partial word
    do_start(64'h100, 16, 1, 0, 0);
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_we_b", IW'(we_b), IW'(0));
    chk("midrst_busy", IW'(busy), IW'(0));
    chk("midrst_in_ready", IW'(in_ready), IW'(0));
    exp_q.delete();
    e_we = 1'b0; e_done = 1'b0; e_ready = 1'b0; e_busy = 1'b0; xfer_done = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0);
    do_start(64'h100, 16, 1, 0, 0);  run(100, -1);

    // Random configurations, including address wrap near the top of RAM
    for (int t = 0; t < 8; t++) begin
      do_start((t % 2) ? longint'(19'h7FFC0 + $urandom_range(63, 0)) : longint'($urandom_range(4095, 0)),
               $urandom_range(40, 1), $urandom_range(4, 1), $urandom_range(300, 0), 1);
      run($urandom_range(100, 30), $urandom_range(20, 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
